window_tap_sequencer: RTL and testbench
=======================================

# window_tap_sequencer

Sequencing controller for the convolution front end. Accepts a row-major pixel stream, keeps the last `(K-1)*cfg_cols + K` pixels in an enable-gated tap shift register, and, once a full KxK window is resident, emits that window's K*K taps one per handshake on a valid/ready port. It sits between the pixel source and the MAC array and back-pressures the source while taps are being read out.

## Interface
- `DATA_WIDTH`, 16, pixel/tap width
- `K`, 3, kernel edge; K ≥ 2
- `MAX_COLS`, 32, largest supported row width; storage depth `DEPTH = (K-1)*MAX_COLS + K`
- `MAX_ROWS`, 32, largest supported frame height
- Reset is asynchronous and active-high; there is one clock.
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  pulse; latches config and begins a frame (IDLE only)
- `cfg_cols`  in  $clog2(MAX_COLS+1)  row width, legal K..MAX_COLS
- `cfg_rows`  in  $clog2(MAX_ROWS+1)  frame height, legal K..MAX_ROWS
- `in_valid` / `in_ready`  in / out  1  pixel handshake
- `in_data`  in  DATA_WIDTH  pixel
- `tap_valid` / `tap_ready`  out / in  1  tap handshake
- `tap_data`  out  DATA_WIDTH  tap value
- `tap_idx`  out  $clog2(K*K)  kernel position, raster order, kr*K+kc
- `tap_last`  out  1  high with `tap_idx == K*K-1`
- `busy`  out  1  state != IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame

## Operation
- Reset: state IDLE, all counters 0, storage cleared to 0. Every output is 0.
- IDLE:
  - `start` with both configs legal latches `cfg_cols`/`cfg_rows`, clears `row`/`col`, and goes to ACCEPT.
  - `start` with an illegal config is ignored; state stays IDLE.
  - `start` outside IDLE is always ignored.
- ACCEPT:
  - `in_ready=1`.
  - On handshake: shift `in_data` into depth 0; the newest pixel is always depth 0.
  - Update counters: `col` wraps at `cfg_cols-1` and increments `row`.
  - If the accepted pixel has `row ≥ K-1` and `col ≥ K-1`, go to EMIT with `t=0`. Otherwise stay in ACCEPT.
  - Gaps in `in_valid` stall without effect.
- EMIT:
  - `in_ready=0`; storage frozen; `tap_valid=1`.
  - Tap t (kr = t/K, kc = t%K) is read from depth `(K-1-kr)*cfg_cols + (K-1-kc)`.
  - Depth is generated incrementally. Start at `base = (K-1)*cfg_cols + K-1`, computed at `start`. Step −1 within a kernel row, and −(cfg_cols−K+1) between kernel rows. No runtime multiplier.
  - On `tap_valid & tap_ready`, t increments.
  - On the handshake with `tap_last`:
    - If the window's pixel was (cfg_rows−1, cfg_cols−1), go to DONE.
    - Otherwise go to ACCEPT.
- DONE: `frame_done=1` for exactly one cycle, then IDLE.
- Wrap-around columns inside storage are never read: windows only start at `col ≥ K-1`. Storage is not cleared between frames, because every tap read in a frame was written in that frame.
- Reset in any state aborts immediately. No `frame_done`, no further taps.

## Timing
- Pixel accept → `tap_valid` for the first tap: next cycle.
- `tap_data`, `tap_idx` and `tap_last` are stable while `tap_valid & !tap_ready`. `tap_valid` never drops before its handshake.
- Steady-state window cost: 1 accept cycle + K*K tap cycles (with `tap_ready=1`).
- Fill phase: 1 pixel/cycle.
- `frame_done` fires the cycle after the final `tap_last` handshake. `busy` falls the cycle after that.

## Structure
- Shared package `conv_pkg`: FSM state encoding (IDLE, ACCEPT, EMIT, DONE), `DEPTH` and counter/width constants derived from K/MAX_COLS/MAX_ROWS.
- Sub-module `tap_shift_reg`:
  - Shift register with the team's shifter semantics (serial in at depth 0, `depth_output` read port) plus a `shift_en` input.
  - Async active-high reset to 0.
  - The controller drives `shift_en` only on the pixel handshake.

## Test plan
- K=3, cols=4, rows=3, pixels 1..12 streamed, `tap_ready=1`:
  - After pixel 11: taps 1,2,3,5,6,7,9,10,11 at idx 0..8, tap_last on 11.
  - After pixel 12: taps 2,3,4,6,7,8,10,11,12.
  - Then `frame_done` pulse and IDLE.
- Same frame, `tap_ready` toggling 1-of-3 cycles: identical tap sequence; data/idx held across every stall; `in_ready=0` throughout EMIT.
- `cfg_cols=MAX_COLS`, `cfg_rows=K`, ramp data: first window taps read from depth DEPTH−1 down to 0; exactly MAX_COLS−K+1 windows.
- Illegal config and busy start:
  - `start` with `cfg_cols=2`: no `busy`, `in_ready` stays 0.
  - `start` pulsed mid-frame: no effect on counters or output.
- `rst` asserted during EMIT at t=4: next cycle all outputs 0, IDLE. A new frame afterwards produces correct taps.
- Random `in_valid` gaps over a 5x5 frame, K=3: 9 windows, all taps match a reference model.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end: controller state encoding,
// default geometry and helpers that derive storage depth and counter widths.
// Latency/backpressure: n/a (types and constants only). No ports.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int K_DEF          = 3;
  localparam int MAX_COLS_DEF   = 32;
  localparam int MAX_ROWS_DEF   = 32;

  // Pixels that must stay resident so a full KxK window can be read.
  function automatic int tap_depth(input int k, input int max_cols);
    return (k - 1) * max_cols + k;
  endfunction

  // Bits needed to index n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// Enable-gated tap shift register: serial in at depth 0, random read by depth.
// Latency: a shift lands on the next rising edge; the read port is combinational.
// Backpressure: none; contents hold whenever shift_en is low.
// Ports: clk, rst (async, active-high, clears storage), shift_en, shift_in,
//        depth (read index), depth_output (value stored at that depth).
module tap_shift_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 67,
  parameter int PTR_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] shift_in,
  input  logic [PTR_W-1:0]      depth,
  output logic [DATA_WIDTH-1:0] depth_output
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {taps[DEPTH-2:0], shift_in};
    end
  end

  // Out-of-range indices read as zero rather than aliasing.
  assign depth_output = (int'(depth) < DEPTH) ? taps[depth] : '0;

endmodule

// File: rtl/window_tap_sequencer.sv
// Streams a row-major frame into tap storage and reads out each full KxK window
// one tap per handshake. Latency: first tap valid the cycle after the pixel that
// completes a window. Backpressure: in_ready is low for the whole tap readout.
// Ports: clk, rst, start + cfg_cols/cfg_rows (frame config), in_valid/in_ready/
//        in_data (pixels), tap_valid/tap_ready/tap_data/tap_idx/tap_last (taps),
//        busy, frame_done.
module window_tap_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int K          = K_DEF,
  parameter int MAX_COLS   = MAX_COLS_DEF,
  parameter int MAX_ROWS   = MAX_ROWS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols,
  input  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          tap_valid,
  input  logic                          tap_ready,
  output logic [DATA_WIDTH-1:0]         tap_data,
  output logic [$clog2(K*K)-1:0]        tap_idx,
  output logic                          tap_last,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int COL_W = $clog2(MAX_COLS + 1);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int IDX_W = $clog2(K * K);
  localparam int KC_W  = idx_w(K);
  localparam int DEPTH = tap_depth(K, MAX_COLS);
  localparam int PTR_W = idx_w(DEPTH);

  localparam logic [COL_W-1:0] C_MIN  = COL_W'(K);
  localparam logic [COL_W-1:0] C_MAX  = COL_W'(MAX_COLS);
  localparam logic [COL_W-1:0] C_KM1  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] R_MIN  = ROW_W'(K);
  localparam logic [ROW_W-1:0] R_MAX  = ROW_W'(MAX_ROWS);
  localparam logic [ROW_W-1:0] R_KM1  = ROW_W'(K - 1);
  localparam logic [IDX_W-1:0] T_LAST = IDX_W'(K * K - 1);
  localparam logic [KC_W-1:0]  KC_END = KC_W'(K - 1);
  localparam logic [PTR_W-1:0] P_KM1  = PTR_W'(K - 1);

  state_t state, state_d;

  logic [COL_W-1:0] cols_q, col;
  logic [ROW_W-1:0] rows_q, row;
  logic [IDX_W-1:0] t;
  logic [KC_W-1:0]  kc;
  logic [PTR_W-1:0] ptr, base, row_step;
  logic             win_last;
  logic [DATA_WIDTH-1:0] rd_data;

  logic cfg_ok, pix_hs, tap_hs, win_ready, at_last_tap;

  assign cfg_ok = (cfg_cols >= C_MIN) && (cfg_cols <= C_MAX) &&
                  (cfg_rows >= R_MIN) && (cfg_rows <= R_MAX);
  assign pix_hs      = (state == ST_ACCEPT) && in_valid;
  assign at_last_tap = (state == ST_EMIT) && (t == T_LAST);
  assign tap_hs      = (state == ST_EMIT) && tap_ready;
  // Windows are only formed once the accepted pixel has K-1 rows and columns
  // behind it, so the wrapped-around columns in storage are never read.
  assign win_ready   = (row >= R_KM1) && (col >= C_KM1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    tap_valid = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && cfg_ok) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid && win_ready) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        tap_valid = 1'b1;
        if (tap_ready && (t == T_LAST)) state_d = win_last ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_q   <= '0;
      rows_q   <= '0;
      row      <= '0;
      col      <= '0;
      t        <= '0;
      kc       <= '0;
      ptr      <= '0;
      base     <= '0;
      row_step <= '0;
      win_last <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start && cfg_ok) begin
        cols_q   <= cfg_cols;
        rows_q   <= cfg_rows;
        row      <= '0;
        col      <= '0;
        // Depth of tap 0 and the jump between kernel rows, fixed per frame so
        // the readout only ever adds/subtracts.
        base     <= P_KM1 * PTR_W'(cfg_cols) + P_KM1;
        row_step <= PTR_W'(cfg_cols) - P_KM1;
      end
      if (pix_hs) begin
        if (col == cols_q - COL_W'(1)) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        if (win_ready) begin
          t        <= '0;
          kc       <= '0;
          ptr      <= base;
          win_last <= (row == rows_q - ROW_W'(1)) && (col == cols_q - COL_W'(1));
        end
      end
      if (tap_hs && !at_last_tap) begin
        t <= t + IDX_W'(1);
        if (kc == KC_END) begin
          kc  <= '0;
          ptr <= ptr - row_step;
        end else begin
          kc  <= kc + KC_W'(1);
          ptr <= ptr - PTR_W'(1);
        end
      end
    end
  end

  tap_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_taps (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (pix_hs),
    .shift_in     (in_data),
    .depth        (ptr),
    .depth_output (rd_data)
  );

  // t is left at the last index after a window, so tap outputs are gated.
  assign tap_data = (state == ST_EMIT) ? rd_data : '0;
  assign tap_idx  = (state == ST_EMIT) ? t : '0;
  assign tap_last = at_last_tap;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_window_tap_sequencer.sv
module tb_window_tap_sequencer;
  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int MAXC = 32;
  localparam int MAXR = 32;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(MAXR + 1);
  localparam int IW   = $clog2(K * K);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_cols;
  logic [RW-1:0] cfg_rows;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tap_valid;
  logic          tap_ready;
  logic [DW-1:0] tap_data;
  logic [IW-1:0] tap_idx;
  logic          tap_last;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  window_tap_sequencer #(
    .DATA_WIDTH (DW),
    .K          (K),
    .MAX_COLS   (MAXC),
    .MAX_ROWS   (MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_cols   (cfg_cols),
    .cfg_rows   (cfg_rows),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tap_valid  (tap_valid),
    .tap_ready  (tap_ready),
    .tap_data   (tap_data),
    .tap_idx    (tap_idx),
    .tap_last   (tap_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},   in_ready,   0);
    chk({tag, "_tap_valid"},  tap_valid,  0);
    chk({tag, "_tap_data"},   tap_data,   0);
    chk({tag, "_tap_idx"},    tap_idx,    0);
    chk({tag, "_tap_last"},   tap_last,   0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Runs one frame. data_mode: 0 ramp (i+1), 1 random. rdy_mode: 0 always,
  // 1 one cycle in three, 2 random. start_at: cycle of a stray start pulse
  // (-1 none). abort_t: assert rst when this tap index is shown (-1 none).
  task automatic run_frame(input int cols, input int rows, input int data_mode,
                           input int vld_pct, input int rdy_mode,
                           input int start_at, input int abort_t);
    int pix[];
    int exp_dat[$];
    int exp_idx[$];
    int p, cyc, wins, wins_exp, r, c, d;
    bit emit_next, done_next, finished;
    pix = new[cols * rows];
    for (int i = 0; i < cols * rows; i++)
      pix[i] = (data_mode == 0) ? (i + 1) : int'($urandom_range(0, 65535));
    // Reference: every window whose bottom-right pixel has r,c >= K-1, in
    // arrival order, taps in raster order over the kernel.
    for (int wr = K - 1; wr < rows; wr++)
      for (int wc = K - 1; wc < cols; wc++)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            exp_dat.push_back(pix[(wr - K + 1 + kr) * cols + (wc - K + 1 + kc)]);
            exp_idx.push_back(kr * K + kc);
          end
    wins_exp = (rows - K + 1) * (cols - K + 1);

    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);

    p = 0; cyc = 0; wins = 0;
    emit_next = 0; done_next = 0; finished = 0;
    while (!finished && cyc < 20000) begin
      if (emit_next) chk("first_tap_latency", tap_valid, 1);
      emit_next = 0;
      if (done_next) begin
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("frame_done_single", frame_done, 0);
        chk("busy_after_done", busy, 0);
        finished = 1;
      end else begin
        if (tap_valid) begin
          chk("in_ready_low_in_emit", in_ready, 0);
          chk("tap_expected", (exp_dat.size() != 0), 1);
          if (exp_dat.size() != 0) begin
            chk("tap_data", tap_data, exp_dat[0]);
            chk("tap_idx", tap_idx, exp_idx[0]);
            chk("tap_last", tap_last, (exp_idx[0] == K * K - 1));
          end
          if (abort_t >= 0 && int'(tap_idx) == abort_t) begin
            rst = 1'b1;
            tap_ready = 1'b0;
            in_valid  = 1'b0;
            finished  = 1;
          end
        end
        if (!finished) begin
          case (rdy_mode)
            0:       tap_ready = 1'b1;
            1:       tap_ready = (cyc % 3 == 2);
            default: tap_ready = ($urandom_range(0, 99) < 50);
          endcase
          if (tap_valid && tap_ready && exp_dat.size() != 0) begin
            if (exp_idx[0] == K * K - 1) wins++;
            void'(exp_dat.pop_front());
            void'(exp_idx.pop_front());
            if (exp_dat.size() == 0) done_next = 1;
          end
          if (p < cols * rows && $urandom_range(0, 99) < vld_pct) begin
            in_valid = 1'b1;
            in_data  = DW'(pix[p]);
          end else begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
          end
          if (in_valid && in_ready) begin
            r = p / cols;
            c = p % cols;
            if (r >= K - 1 && c >= K - 1) emit_next = 1;
            p++;
          end
          // Stray start with a different legal config; must be ignored.
          if (cyc == start_at) begin
            start    = 1'b1;
            cfg_cols = CW'(K);
            cfg_rows = RW'(K);
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
          cyc++;
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (abort_t < 0) begin
      chk("frame_completed", finished, 1);
      chk("window_count", wins, wins_exp);
    end else begin
      chk("abort_reached", rst, 1);
    end
    d = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_cols = '0;
    cfg_rows = '0;
    in_valid = 1'b0;
    in_data = '0;
    tap_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");

    // Small 4x3 frame, ramp data, always ready.
    run_frame(4, 3, 0, 100, 0, -1, -1);
    // Same frame with ready only one cycle in three.
    run_frame(4, 3, 0, 100, 1, -1, -1);

    // Widest rows, minimum height.
    run_frame(MAXC, K, 0, 100, 0, -1, -1);

    // Illegal configs are ignored.
    cfg_cols = CW'(2); cfg_rows = RW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_cols_busy", busy, 0);
    chk("illegal_cols_in_ready", in_ready, 0);
    @(negedge clk);
    chk("illegal_cols_busy_later", busy, 0);
    cfg_cols = CW'(MAXC + 1); cfg_rows = RW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_wide_busy", busy, 0);
    cfg_cols = CW'(4); cfg_rows = RW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_rows_busy", busy, 0);

    // Stray start mid-frame, random data.
    run_frame(6, 4, 1, 100, 0, 9, -1);

    // Reset during EMIT at tap 4.
    run_frame(4, 3, 1, 100, 1, -1, 4);
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("abort_released");
    run_frame(4, 3, 1, 100, 0, -1, -1);

    // Random valid gaps and random ready over a 5x5 frame.
    run_frame(5, 5, 1, 60, 2, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
